// File: rtl/irq_pending_ctrl_if.sv
// Request/grant bundle for irq_pending_ctrl.
// master: request source, mask writer and grant consumer.
// slave:  the pending controller.
// Signals: req_in, mask_wr, mask_data, out_ready, ovf_clr go master->slave;
// out_valid, out_index, pending_o, mask_o, overflow_o go slave->master.
interface irq_pending_ctrl_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req_in;
  logic             mask_wr;
  logic [N-1:0]     mask_data;
  logic             out_ready;
  logic             ovf_clr;
  logic             out_valid;
  logic [IDX_W-1:0] out_index;
  logic [N-1:0]     pending_o;
  logic [N-1:0]     mask_o;
  logic             overflow_o;

  modport master (
    output req_in, mask_wr, mask_data, out_ready, ovf_clr,
    input  out_valid, out_index, pending_o, mask_o, overflow_o
  );

  modport slave (
    input  req_in, mask_wr, mask_data, out_ready, ovf_clr,
    output out_valid, out_index, pending_o, mask_o, overflow_o
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Request-capture stage ahead of the priority encoder.
// Rising edges on req_in latch into a pending register. The highest-index
// pending line that is not masked is granted on a valid/ready port, and its
// pending bit is cleared on handshake. A sticky overflow flags an edge that
// arrived on a line that was already pending.
// Ports: clk, rst_n (synchronous, active-low), bus (irq_pending_ctrl_if.slave).
// Only 2**IDX_W == N is supported.
//
// state   | meaning
// IDLE    | no grant offered; looking for an unmasked pending line
// PRESENT | out_index offered with out_valid=1, held until out_ready
module irq_pending_ctrl #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  irq_pending_ctrl_if.slave bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state;
  logic [N-1:0]     req_prev;
  logic [N-1:0]     pending;
  logic [N-1:0]     mask;
  logic             out_valid;
  logic [IDX_W-1:0] out_index;
  logic             overflow;

  logic [N-1:0]     rise;
  logic [N-1:0]     clr_vec;
  logic [N-1:0]     eligible;
  logic [IDX_W-1:0] sel;

  assign rise     = bus.req_in & ~req_prev;
  assign clr_vec  = (out_valid && bus.out_ready) ? (N'(1) << out_index) : '0;
  assign eligible = pending & ~mask;

  // Ascending scan so the highest set index is the one left in sel.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) sel = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    // Sampled in reset too, so lines held high through reset give no edge.
    req_prev <= bus.req_in;
    if (!rst_n) begin
      pending   <= '0;
      mask      <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      overflow  <= 1'b0;
      state     <= IDLE;
    end else begin
      // A rise on the bit being served re-arms it rather than overflowing.
      pending <= (pending & ~clr_vec) | rise;
      if (bus.mask_wr) mask <= bus.mask_data;

      if (|(rise & pending & ~clr_vec)) overflow <= 1'b1;
      else if (bus.ovf_clr)             overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (|eligible) begin
            out_index <= sel;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          // No preemption and no withdrawal: only the handshake ends a grant.
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_index  = out_index;
  assign bus.pending_o  = pending;
  assign bus.mask_o     = mask;
  assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
module tb_irq_pending_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  irq_pending_ctrl_if #(.N(8), .IDX_W(3)) bus ();

  irq_pending_ctrl #(.N(8), .IDX_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] req;
    logic       ready;
    logic       mwr;
    logic [7:0] mdata;
    logic       ev;
    logic [2:0] eidx;
    logic [7:0] epend;
    logic [7:0] emask;
    logic       eovf;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string what, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", what, id, act, exp);
    end
  endtask

  // Drive one cycle of inputs away from the edge, then sample just after it.
  task automatic cyc(input logic [7:0] req, input logic ready, input logic oclr,
                     input logic rstn, input logic mwr, input logic [7:0] mdata);
    @(negedge clk);
    bus.req_in    = req;
    bus.out_ready = ready;
    bus.ovf_clr   = oclr;
    bus.mask_wr   = mwr;
    bus.mask_data = mdata;
    rst_n         = rstn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           req    rdy  mwr  mdata  ev   idx   pend   mask   ovf
    for (int i = 0; i < 5; i++)
      tbl[i] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{8'h20, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h20, 8'h00, 1'b0};
    tbl[7]  = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 3'd5, 8'h20, 8'h00, 1'b0};
    tbl[8]  = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h44, 8'h00, 1'b0};
    tbl[10] = '{8'h44, 1'b0, 1'b0, 8'h00, 1'b1, 3'd6, 8'h44, 8'h00, 1'b0};
    tbl[11] = '{8'hC4, 1'b0, 1'b0, 8'h00, 1'b1, 3'd6, 8'hC4, 8'h00, 1'b0};
    tbl[12] = '{8'hC4, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h84, 8'h00, 1'b0};
    tbl[13] = '{8'hC4, 1'b1, 1'b0, 8'h00, 1'b1, 3'd7, 8'h84, 8'h00, 1'b0};
    tbl[14] = '{8'hC4, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h04, 8'h00, 1'b0};
    tbl[15] = '{8'hC4, 1'b1, 1'b0, 8'h00, 1'b1, 3'd2, 8'h04, 8'h00, 1'b0};
    tbl[16] = '{8'hC4, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[17] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[18] = '{8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 3'd0, 8'h00, 8'h80, 1'b0};
    tbl[19] = '{8'h88, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h88, 8'h80, 1'b0};
    tbl[20] = '{8'h88, 1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 8'h88, 8'h80, 1'b0};
    tbl[21] = '{8'h88, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h80, 8'h80, 1'b0};
    tbl[22] = '{8'h88, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h80, 8'h80, 1'b0};
    tbl[23] = '{8'h88, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 8'h80, 8'h00, 1'b0};
    tbl[24] = '{8'h88, 1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 8'h80, 8'h00, 1'b0};
    tbl[25] = '{8'h88, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[26] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};

    bus.req_in = 8'hFF; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
    bus.mask_wr = 1'b0; bus.mask_data = 8'h00; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_valid", 0, 32'(bus.out_valid),  0);
    chk("rst_index", 0, 32'(bus.out_index),  0);
    chk("rst_pend",  0, 32'(bus.pending_o),  0);
    chk("rst_mask",  0, 32'(bus.mask_o),     0);
    chk("rst_ovf",   0, 32'(bus.overflow_o), 0);

    for (int i = 0; i < 27; i++) begin
      cyc(tbl[i].req, tbl[i].ready, 1'b0, 1'b1, tbl[i].mwr, tbl[i].mdata);
      chk("valid", i, 32'(bus.out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk("index", i, 32'(bus.out_index), 32'(tbl[i].eidx));
      chk("pending", i, 32'(bus.pending_o),  32'(tbl[i].epend));
      chk("mask",    i, 32'(bus.mask_o),     32'(tbl[i].emask));
      chk("ovf",     i, 32'(bus.overflow_o), 32'(tbl[i].eovf));
    end

    // Overflow: second edge on a pending line, clear, set-beats-clear,
    // and an edge coinciding with its own handshake.
    cyc(8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("ov_pend", 100, 32'(bus.pending_o), 32'h10);
    cyc(8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("ov_valid", 101, 32'(bus.out_valid), 1);
    chk("ov_index", 101, 32'(bus.out_index), 4);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("ov_quiet", 102, 32'(bus.overflow_o), 0);
    cyc(8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("ov_set", 103, 32'(bus.overflow_o), 1);
    chk("ov_hold_index", 103, 32'(bus.out_index), 4);
    cyc(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("ov_clr", 104, 32'(bus.overflow_o), 0);
    cyc(8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("ov_set_wins", 105, 32'(bus.overflow_o), 1);
    cyc(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("ov_clr2", 106, 32'(bus.overflow_o), 0);
    cyc(8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("hs_rise_pend",  107, 32'(bus.pending_o),  32'h10);
    chk("hs_rise_ovf",   107, 32'(bus.overflow_o), 0);
    chk("hs_rise_valid", 107, 32'(bus.out_valid),  0);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("regrant_valid", 108, 32'(bus.out_valid), 1);
    chk("regrant_index", 108, 32'(bus.out_index), 4);
    cyc(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("regrant_done", 109, 32'(bus.pending_o), 0);

    // Reset in the middle of a presented grant.
    cyc(8'h45, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc(8'h45, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("mid_valid", 110, 32'(bus.out_valid), 1);
    chk("mid_index", 110, 32'(bus.out_index), 6);
    chk("mid_pend",  110, 32'(bus.pending_o), 32'h45);
    cyc(8'h45, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("mid_rst_valid", 111, 32'(bus.out_valid), 0);
    chk("mid_rst_pend",  111, 32'(bus.pending_o), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h45, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("no_replay_valid", 112 + i, 32'(bus.out_valid), 0);
      chk("no_replay_pend",  112 + i, 32'(bus.pending_o), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
